// File: rtl/fifo_ptr_flags.sv
// FIFO pointer/status controller: owns wr/rd pointers, registered full/empty/almost flags, count, sticky errors.
// Flags and count reflect an accepted op one edge later; writes at full and reads at empty are refused (wr_ok/rd_ok low).
module fifo_ptr_flags #(
    parameter int ADDR = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [ADDR:0]   af_thresh,
    input  logic [ADDR:0]   ae_thresh,
    input  logic            clr_err,
    output logic            wr_ok,
    output logic            rd_ok,
    output logic [ADDR-1:0] waddr,
    output logic [ADDR-1:0] raddr,
    output logic [ADDR:0]   count,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow
);

    logic [ADDR:0] wptr;
    logic [ADDR:0] rptr;
    logic [ADDR:0] wptr_n;
    logic [ADDR:0] rptr_n;
    logic [ADDR:0] count_n;
    logic          full_n;
    logic          empty_n;

    // Accept decisions use only registered flags, so there is no path from enables to flags.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign waddr = wptr[ADDR-1:0];
    assign raddr = rptr[ADDR-1:0];

    always_comb begin
        wptr_n  = wptr + {{ADDR{1'b0}}, wr_ok};
        rptr_n  = rptr + {{ADDR{1'b0}}, rd_ok};
        count_n = wptr_n - rptr_n;
        empty_n = (wptr_n == rptr_n);
        // Extra MSB distinguishes a full wrap from empty when the addresses match.
        full_n  = (wptr_n[ADDR] != rptr_n[ADDR]) && (wptr_n[ADDR-1:0] == rptr_n[ADDR-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= wptr_n;
            rptr         <= rptr_n;
            count        <= count_n;
            full         <= full_n;
            empty        <= empty_n;
            almost_full  <= (count_n >= af_thresh);
            almost_empty <= (count_n <= ae_thresh);
            // A new error event takes priority over a clear on the same edge.
            overflow     <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow    <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_ptr_flags.sv
// Self-checking bench for fifo_ptr_flags: directed scenarios plus randomized traffic against an occupancy-level model.
module tb_fifo_ptr_flags;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic            rd_en;
    logic [ADDR:0]   af_thresh;
    logic [ADDR:0]   ae_thresh;
    logic            clr_err;
    logic            wr_ok;
    logic            rd_ok;
    logic [ADDR-1:0] waddr;
    logic [ADDR-1:0] raddr;
    logic [ADDR:0]   count;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic            overflow;
    logic            underflow;

    fifo_ptr_flags #(.ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .wr_ok(wr_ok), .rd_ok(rd_ok), .waddr(waddr), .raddr(raddr),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: total writes/reads accepted and occupancy as plain integers.
    int m_wtot, m_rtot, m_cnt;
    bit m_af, m_ae, m_ovf, m_unf;
    bit s_wok, s_rok, e_wok, e_rok;

    function automatic void model_reset();
        m_wtot = 0; m_rtot = 0; m_cnt = 0;
        m_af = 0; m_ae = 1; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {full, empty, almost_full, almost_empty, overflow, underflow, count, waddr, raddr};
    endfunction

    function automatic logic [21:0] mdl_vec();
        logic [ADDR:0]   c;
        logic [ADDR-1:0] wa;
        logic [ADDR-1:0] ra;
        c  = (ADDR+1)'(m_cnt);
        wa = ADDR'(m_wtot % DEPTH);
        ra = ADDR'(m_rtot % DEPTH);
        return {m_cnt == DEPTH, m_cnt == 0, m_af, m_ae, m_ovf, m_unf, c, wa, ra};
    endfunction

    // Drive one cycle from posedge+1, sample accept strobes before the edge, update the model at the edge.
    task automatic tick(input bit w, input bit r, input bit c);
        bit wok, rok;
        wr_en = w; rd_en = r; clr_err = c;
        #2;
        s_wok = wr_ok; s_rok = rd_ok;
        wok = w && (m_cnt < DEPTH);
        rok = r && (m_cnt > 0);
        e_wok = wok; e_rok = rok;
        @(posedge clk);
        m_ovf  = (w && m_cnt == DEPTH) || (m_ovf && !c);
        m_unf  = (r && m_cnt == 0) || (m_unf && !c);
        m_wtot = m_wtot + int'(wok);
        m_rtot = m_rtot + int'(rok);
        m_cnt  = m_wtot - m_rtot;
        m_af   = m_cnt >= int'(af_thresh);
        m_ae   = m_cnt <= int'(ae_thresh);
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), mdl_vec());
        end
        for (int i = 0; i < 7; i++) tick(1, 0, 0);
        n_chk++;
        if (count !== 6'd7) begin
            n_fail++; $display("FAIL reset_pre_count: got %0d expected 7", count);
        end
        #2 rst_n = 0;
        wr_en = 1; rd_en = 1;
        #1;
        model_reset();
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", dut_vec(), mdl_vec());
        end
        n_chk++;
        if ({wr_ok, rd_ok} !== 2'b10) begin
            n_fail++; $display("FAIL reset_accept: got %b expected 10", {wr_ok, rd_ok});
        end
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0;
        rst_n = 1;
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL reset_held_edge: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1, 0, 0);
            n_chk++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL fill_vec %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            n_chk++;
            if ({almost_empty, almost_full, full, count} !== {i <= 3, i >= 28, i == DEPTH, 6'(i)}) begin
                n_fail++;
                $display("FAIL fill_flags %0d: got ae=%b af=%b full=%b cnt=%0d", i, almost_empty, almost_full, full, count);
            end
        end
        tick(1, 0, 0);
        n_chk++;
        if ({s_wok, overflow, count} !== {1'b0, 1'b1, 6'd32}) begin
            n_fail++; $display("FAIL fill_overflow: got wok=%b ovf=%b cnt=%0d expected 0 1 32", s_wok, overflow, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(0, 1, 0);
            n_chk++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL drain_vec %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            n_chk++;
            if ({full, empty, count} !== {1'b0, i == DEPTH, 6'(DEPTH - i)}) begin
                n_fail++; $display("FAIL drain_flags %0d: got full=%b empty=%b cnt=%0d", i, full, empty, count);
            end
        end
        tick(0, 1, 0);
        n_chk++;
        if ({s_rok, underflow, count} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL drain_underflow: got rok=%b unf=%b cnt=%0d expected 0 1 0", s_rok, underflow, count);
        end
        tick(0, 0, 1);
        n_chk++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++; $display("FAIL clr_err: got %b expected 00", {overflow, underflow});
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) tick(1, 0, 0);
        tick(1, 1, 0);
        n_chk++;
        if ({s_wok, s_rok, full, count} !== {1'b0, 1'b1, 1'b0, 6'd31}) begin
            n_fail++; $display("FAIL simul_full: got wok=%b rok=%b full=%b cnt=%0d expected 0 1 0 31", s_wok, s_rok, full, count);
        end
        for (int i = 0; i < 31; i++) tick(0, 1, 0);
        tick(1, 1, 0);
        n_chk++;
        if ({s_wok, s_rok, empty, count} !== {1'b1, 1'b0, 1'b0, 6'd1}) begin
            n_fail++; $display("FAIL simul_empty: got wok=%b rok=%b empty=%b cnt=%0d expected 1 0 0 1", s_wok, s_rok, empty, count);
        end
        for (int i = 0; i < 9; i++) tick(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1, 1, 0);
            n_chk++;
            if ({s_wok, s_rok, count} !== {1'b1, 1'b1, 6'd10}) begin
                n_fail++; $display("FAIL simul_mid %0d: got wok=%b rok=%b cnt=%0d expected 1 1 10", i, s_wok, s_rok, count);
            end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR-1:0] prev;
        bit saw_wrap;
        saw_wrap = 0;
        for (int i = 0; i < 5; i++) tick(0, 1, 0);
        prev = waddr;
        for (int i = 0; i < 45; i++) begin
            tick(1, 1, 0);
            if (prev == 5'd31 && waddr == 5'd0) saw_wrap = 1;
            prev = waddr;
            n_chk++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL wrap_vec %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            n_chk++;
            if ({full, empty, count} !== {1'b0, 1'b0, 6'd5}) begin
                n_fail++; $display("FAIL wrap_flags %0d: got full=%b empty=%b cnt=%0d", i, full, empty, count);
            end
        end
        n_chk++;
        if (saw_wrap !== 1'b1) begin
            n_fail++; $display("FAIL wrap_seen: got %b expected 1", saw_wrap);
        end
    endtask

    task automatic test_err_priority();
        for (int i = 0; i < 27; i++) tick(1, 0, 0);
        tick(1, 0, 1);
        n_chk++;
        if ({full, overflow} !== 2'b11) begin
            n_fail++; $display("FAIL err_priority: got full=%b ovf=%b expected 1 1", full, overflow);
        end
        tick(0, 0, 1);
        n_chk++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b expected 0", overflow);
        end
        for (int i = 0; i < DEPTH; i++) tick(0, 1, 0);
    endtask

    task automatic test_thresholds();
        af_thresh = 6'd0; ae_thresh = 6'd32;
        #2 rst_n = 0;
        #1 model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        tick(0, 0, 0);
        n_chk++;
        if ({almost_full, almost_empty} !== 2'b11) begin
            n_fail++; $display("FAIL thresh_first_edge: got af=%b ae=%b expected 1 1", almost_full, almost_empty);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1, 0, 0);
            n_chk++;
            if ({almost_full, almost_empty} !== 2'b11 || dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL thresh_hold %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        int wb, rb;
        bit w, r, c;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_thresh = 6'($urandom_range(0, 40));
                ae_thresh = 6'($urandom_range(0, 40));
            end
            case ((i / 100) % 4)
                0: begin wb = 75; rb = 30; end
                1: begin wb = 30; rb = 75; end
                2: begin wb = 50; rb = 50; end
                default: begin wb = 95; rb = 10; end
            endcase
            if (i == 250) begin
                #2 rst_n = 0;
                #1 model_reset();
                n_chk++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++; $display("FAIL rand_reset: got %h expected %h", dut_vec(), mdl_vec());
                end
                @(posedge clk);
                #1 rst_n = 1;
            end
            w = ($urandom_range(0, 99) < wb);
            r = ($urandom_range(0, 99) < rb);
            c = ($urandom_range(0, 15) == 0);
            tick(w, r, c);
            n_chk++;
            if ({s_wok, s_rok} !== {e_wok, e_rok} || dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rand %0d: got ok=%b%b vec=%h expected ok=%b%b vec=%h",
                         i, s_wok, s_rok, dut_vec(), e_wok, e_rok, mdl_vec());
            end
        end
    endtask

    initial begin
        rst_n = 0; wr_en = 0; rd_en = 0; clr_err = 0;
        af_thresh = 6'd28; ae_thresh = 6'd3;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_err_priority();
        test_thresholds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
